// File: rtl/alu_serial.sv
`default_nettype none
// ============================================================================
// Module   : alu_serial
// Summary  : Digit-serial ALU. Processes WIDTH-bit operands DIGIT bits per
//            clock, least-significant digit first, with a carry register
//            chained between digits. Provides a start/busy/done handshake,
//            latched operands and zero/carry/overflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module alu_serial #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [2:0]       operation_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o
);

    localparam int c_num_digits = WIDTH / DIGIT;
    localparam int c_cnt_w      = (c_num_digits > 1) ? $clog2(c_num_digits) : 1;
    localparam logic [c_cnt_w-1:0] c_last_digit = c_cnt_w'(c_num_digits - 1);

    localparam logic [2:0] c_op_and = 3'b001;
    localparam logic [2:0] c_op_or  = 3'b010;
    localparam logic [2:0] c_op_add = 3'b011;
    localparam logic [2:0] c_op_sub = 3'b100;
    localparam logic [2:0] c_op_nor = 3'b101;
    localparam logic [2:0] c_op_slt = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2:0]           r_op;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_carry;
    logic [WIDTH-1:0]     r_acc;

    logic [31:0]          w_base;
    logic [DIGIT-1:0]     w_a_dig;
    logic [DIGIT-1:0]     w_b_dig;
    logic [DIGIT-1:0]     w_b_eff;
    logic                 w_is_sub;
    logic [DIGIT:0]       w_sum;
    logic [DIGIT-1:0]     w_dres;
    logic [WIDTH-1:0]     w_full;
    logic                 w_add_ovf;
    logic                 w_sub_ovf;
    logic [WIDTH-1:0]     w_result;
    logic                 w_cout;
    logic                 w_ovf;

    // Select the current digit of each latched operand and compute it.
    always_comb begin
        w_base   = 32'(r_cnt) * 32'(DIGIT);
        w_a_dig  = DIGIT'(r_a >> w_base);
        w_b_dig  = DIGIT'(r_b >> w_base);
        w_is_sub = (r_op == c_op_sub) || (r_op == c_op_slt);
        w_b_eff  = w_is_sub ? ~w_b_dig : w_b_dig;
        w_sum    = {1'b0, w_a_dig} + {1'b0, w_b_eff} + {{DIGIT{1'b0}}, r_carry};
        case (r_op)
            c_op_and: w_dres = w_a_dig & w_b_dig;
            c_op_or:  w_dres = w_a_dig | w_b_dig;
            c_op_nor: w_dres = ~w_a_dig & ~w_b_dig;
            c_op_add,
            c_op_sub,
            c_op_slt: w_dres = w_sum[DIGIT-1:0];
            default:  w_dres = '0;
        endcase
    end

    // Assemble the full-width value and flags as they stand on the last digit.
    always_comb begin
        // Accumulator slots not yet written are zero, so OR-ing places the digit.
        w_full    = r_acc | (WIDTH'(w_dres) << w_base);
        w_add_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_full[WIDTH-1] != r_a[WIDTH-1]);
        w_sub_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_full[WIDTH-1] != r_a[WIDTH-1]);
        w_result  = w_full;
        w_cout    = 1'b0;
        w_ovf     = 1'b0;
        case (r_op)
            c_op_add: begin
                w_cout = w_sum[DIGIT];
                w_ovf  = w_add_ovf;
            end
            c_op_sub: begin
                w_cout = w_sum[DIGIT];
                w_ovf  = w_sub_ovf;
            end
            // Sign of the difference corrected by overflow gives a true signed compare.
            c_op_slt: w_result = WIDTH'(w_full[WIDTH-1] ^ w_sub_ovf);
            default:  ;
        endcase
    end

    // Control FSM, digit datapath registers and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_acc      <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            result_o   <= '0;
            zero_o     <= 1'b0;
            cout_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (r_state)
                ST_IDLE,
                ST_DONE: begin
                    if (start_i) begin
                        r_state <= ST_RUN;
                        r_a     <= src1_i;
                        r_b     <= src2_i;
                        r_op    <= operation_i;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_carry <= (operation_i == c_op_sub) || (operation_i == c_op_slt);
                        busy_o  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        busy_o  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_acc   <= w_full;
                    r_carry <= w_sum[DIGIT];
                    r_cnt   <= r_cnt + c_cnt_w'(1);
                    if (r_cnt == c_last_digit) begin
                        r_state    <= ST_DONE;
                        busy_o     <= 1'b0;
                        done_o     <= 1'b1;
                        result_o   <= w_result;
                        zero_o     <= (w_result == '0);
                        cout_o     <= w_cout;
                        overflow_o <= w_ovf;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_serial.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_alu_serial
// Summary  : Directed scoreboard bench for alu_serial at DIGIT=4, 32 and 1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_serial;

    localparam logic [2:0] c_and = 3'b001;
    localparam logic [2:0] c_or  = 3'b010;
    localparam logic [2:0] c_add = 3'b011;
    localparam logic [2:0] c_sub = 3'b100;
    localparam logic [2:0] c_nor = 3'b101;
    localparam logic [2:0] c_slt = 3'b110;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  start_v;
    logic [2:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [2:0]  zero_v;
    logic [2:0]  cout_v;
    logic [2:0]  ovf_v;
    logic [31:0] res_v [3];

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_serial #(.WIDTH(32), .DIGIT(4)) u_d4 (
        .clk_i(clk), .rst_n(rst_n), .start_i(start_v[0]), .operation_i(op),
        .src1_i(src1), .src2_i(src2), .busy_o(busy_v[0]), .done_o(done_v[0]),
        .result_o(res_v[0]), .zero_o(zero_v[0]), .cout_o(cout_v[0]), .overflow_o(ovf_v[0])
    );

    alu_serial #(.WIDTH(32), .DIGIT(32)) u_d32 (
        .clk_i(clk), .rst_n(rst_n), .start_i(start_v[1]), .operation_i(op),
        .src1_i(src1), .src2_i(src2), .busy_o(busy_v[1]), .done_o(done_v[1]),
        .result_o(res_v[1]), .zero_o(zero_v[1]), .cout_o(cout_v[1]), .overflow_o(ovf_v[1])
    );

    alu_serial #(.WIDTH(32), .DIGIT(1)) u_d1 (
        .clk_i(clk), .rst_n(rst_n), .start_i(start_v[2]), .operation_i(op),
        .src1_i(src1), .src2_i(src2), .busy_o(busy_v[2]), .done_o(done_v[2]),
        .result_o(res_v[2]), .zero_o(zero_v[2]), .cout_o(cout_v[2]), .overflow_o(ovf_v[2])
    );

    // Reference behaviour of one complete operation.
    function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [32:0] t;
        e.res  = '0;
        e.cout = 1'b0;
        e.ovf  = 1'b0;
        case (o)
            c_and: e.res = a & b;
            c_or:  e.res = a | b;
            c_nor: e.res = ~(a | b);
            c_add: begin
                t      = {1'b0, a} + {1'b0, b};
                e.res  = t[31:0];
                e.cout = t[32];
                e.ovf  = (a[31] == b[31]) && (t[31] != a[31]);
            end
            c_sub: begin
                t      = {1'b0, a} + {1'b0, ~b} + 33'd1;
                e.res  = t[31:0];
                e.cout = t[32];
                e.ovf  = (a[31] != b[31]) && (t[31] != a[31]);
            end
            c_slt: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: e.res = '0;
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_all_zero(input int k, input string tag);
        check({tag, "_result"}, res_v[k], 32'd0);
        check({tag, "_zero"},   32'(zero_v[k]), 32'd0);
        check({tag, "_cout"},   32'(cout_v[k]), 32'd0);
        check({tag, "_ovf"},    32'(ovf_v[k]),  32'd0);
        check({tag, "_busy"},   32'(busy_v[k]), 32'd0);
        check({tag, "_done"},   32'(done_v[k]), 32'd0);
    endtask

    // Present an operation to instance k; called 1ns after a rising edge.
    task automatic issue(input int k, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        src1 = a;
        src2 = b;
        op   = o;
        start_v[k] = 1'b1;
        sb.push_back(model(o, a, b));
        @(posedge clk);
        #1;
        start_v[k] = 1'b0;
        check("busy_rise", 32'(busy_v[k]), 32'd1);
    endtask

    // Wait (bounded) for done on instance k and score the result.
    task automatic wait_done(input int k, input int lat, input bit disturb);
        int   cycles   = 0;
        int   busy_cnt = 0;
        exp_t e;
        while (done_v[k] !== 1'b1 && cycles < 200) begin
            if (busy_v[k] === 1'b1) busy_cnt++;
            if (disturb && cycles == 2) begin
                start_v[k] = 1'b1;
                src1 = $urandom;
                src2 = $urandom;
                op   = c_and;
            end
            if (disturb && cycles == 3) start_v[k] = 1'b0;
            @(posedge clk);
            #1;
            cycles++;
        end
        check("latency",    32'(cycles),   32'(lat));
        check("busy_count", 32'(busy_cnt), 32'(lat));
        check("busy_fall",  32'(busy_v[k]), 32'd0);
        check("sb_size",    32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("result", res_v[k],          e.res);
            check("zero",   32'(zero_v[k]),    32'(e.zero));
            check("cout",   32'(cout_v[k]),    32'(e.cout));
            check("ovf",    32'(ovf_v[k]),     32'(e.ovf));
        end
    endtask

    task automatic idle_after(input int k);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done_v[k]), 32'd0);
    endtask

    task automatic run(input int k, input int lat, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        issue(k, o, a, b);
        wait_done(k, lat, 1'b0);
        idle_after(k);
    endtask

    initial begin
        int done_seen;
        rst_n   = 1'b0;
        start_v = '0;
        op      = '0;
        src1    = '0;
        src2    = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check_all_zero(k, "reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Arithmetic boundary cases, N = 8
        run(0, 8, c_add, 32'h7FFF_FFFF, 32'h0000_0001);
        run(0, 8, c_add, 32'hFFFF_FFFF, 32'h0000_0001);
        run(0, 8, c_sub, 32'd5, 32'd5);
        run(0, 8, c_sub, 32'h8000_0000, 32'h0000_0001);
        run(0, 8, c_sub, 32'd3, 32'd10);
        run(0, 8, c_slt, 32'hFFFF_FFFF, 32'h0000_0001);
        run(0, 8, c_slt, 32'h7FFF_FFFF, 32'h8000_0000);
        run(0, 8, c_slt, 32'd3, 32'd3);
        run(0, 8, c_slt, 32'h8000_0000, 32'h7FFF_FFFF);

        // Logic and invalid opcodes
        run(0, 8, c_and, 32'hF0F0_F0F0, 32'hFF00_FF00);
        run(0, 8, c_or,  32'hF0F0_F0F0, 32'hFF00_FF00);
        run(0, 8, c_nor, 32'hF0F0_F0F0, 32'hFF00_FF00);
        run(0, 8, 3'b111, 32'hF0F0_F0F0, 32'hFF00_FF00);
        run(0, 8, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00);

        // Start pulse and operand changes while running are ignored
        issue(0, c_add, 32'h1234_5678, 32'h1111_1111);
        wait_done(0, 8, 1'b1);
        idle_after(0);

        // Back-to-back issue from the DONE cycle
        issue(0, c_add, 32'h0000_00FF, 32'h0000_0F01);
        wait_done(0, 8, 1'b0);
        issue(0, c_sub, 32'hDEAD_BEEF, 32'h0000_BEEF);
        wait_done(0, 8, 1'b0);
        idle_after(0);

        // Asynchronous reset in the middle of an operation
        issue(0, c_add, 32'h0000_0001, 32'h0000_0002);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero(0, "abort");
        if (sb.size() > 0) void'(sb.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done_v[0] === 1'b1) done_seen++;
        end
        check("no_done_after_abort", 32'(done_seen), 32'd0);
        run(0, 8, c_add, 32'h0F0F_0F0F, 32'h0101_0101);

        // N = 1 and N = 32 variants
        run(1, 1,  c_add, 32'h7FFF_FFFF, 32'h0000_0001);
        run(1, 1,  c_sub, 32'h8000_0000, 32'h0000_0001);
        run(1, 1,  c_slt, 32'h7FFF_FFFF, 32'h8000_0000);
        run(2, 32, c_add, 32'h7FFF_FFFF, 32'h0000_0001);
        run(2, 32, c_sub, 32'h8000_0000, 32'h0000_0001);
        run(2, 32, c_slt, 32'hFFFF_FFFF, 32'h0000_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_serial.md
Name: alu_serial

Overview:
- Parametrised multi-cycle ALU. Processes WIDTH-bit operands DIGIT bits per clock, least-significant digit first.
- Carry is chained between digits through a carry register.
- Opcode set matches the single-bit ALU slice: AND, OR, ADD, SUB, NOR, SLT.
- Adds over the slice: a start/busy/done handshake, latched operands, and zero/carry/overflow flags.
- Sits beside the datapath as a small-area ALU alternative.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 <= DIGIT <= WIDTH; N = WIDTH/DIGIT cycles per operation.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start_i  input  1  request; sampled only when not busy.
- operation_i  input  3  001 AND, 010 OR, 011 ADD, 100 SUB, 101 NOR, 110 SLT; 000/111 invalid.
- src1_i  input  WIDTH  operand A, two's complement.
- src2_i  input  WIDTH  operand B, two's complement.
- busy_o  output  1  high while digits are being processed.
- done_o  output  1  one-cycle pulse; result_o and flags are valid from this cycle.
- result_o  output  WIDTH  result.
- zero_o  output  1  high when result_o == 0.
- cout_o  output  1  carry out of MSB (ADD/SUB only).
- overflow_o  output  1  signed overflow (ADD/SUB only).

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; all outputs 0 (result_o=0, zero_o=0, cout_o=0, overflow_o=0, busy_o=0, done_o=0); digit counter and carry register cleared.
- States: IDLE, RUN, DONE.
  - IDLE/DONE, start_i=1 at edge E0 -> RUN. At E0, latch src1_i, src2_i and operation_i; counter=0; carry=1 for SUB/SLT, else 0.
  - RUN: each edge processes digit[counter] and increments the counter. At edge EN (the N-th digit) -> DONE.
  - DONE: lasts exactly one cycle, then IDLE unless start_i=1, which is accepted (back-to-back issue).
- Outputs by state:
  - busy_o=1 exactly in RUN.
  - done_o=1 exactly in DONE.
  - result_o and flags update only at edge EN and hold until the next EN or reset.
- Latency: done_o is high in the cycle following edge EN, i.e. N cycles after the start edge. Throughput: one operation per N+1 cycles.
- start_i while busy_o=1 is ignored. Input changes after E0 do not affect the operation in flight.
- Per-digit function, with a = A digit, b = B digit, bi = ~b:
  - AND: a&b.
  - OR: a|b.
  - NOR: ~a&bi.
  - ADD: a+b+carry.
  - SUB/SLT: a+bi+carry. Digit carry-out goes to the carry register.
- Flags at EN:
  - cout_o: final carry for ADD/SUB (SUB: 1 = no borrow); 0 otherwise.
  - ADD overflow_o = (A[W-1]==B[W-1]) & (R[W-1]!=A[W-1]).
  - SUB overflow_o = (A[W-1]!=B[W-1]) & (R[W-1]!=A[W-1]).
  - overflow_o=0 for all other ops.
  - SLT: result_o = {WIDTH-1 zeros, set}, where set = diff[W-1] ^ sub_overflow (correct signed compare); cout_o=0, overflow_o=0.
  - zero_o = (result_o==0) for every opcode.
- Invalid opcode: same timing; result_o=0, zero_o=1, cout_o=0, overflow_o=0.
- Reset during RUN/DONE: immediate return to IDLE with all outputs 0. No done_o pulse for the aborted operation.
- N=1 (DIGIT=WIDTH): RUN lasts one cycle; done_o at start edge +1 cycle.
- No combinational path from inputs to outputs.

Test Plan:
- WIDTH=32, DIGIT=4: ADD 0x7FFFFFFF+0x00000001 -> done_o 8 cycles after start, result 0x80000000, overflow_o=1, cout_o=0, zero_o=0; busy_o high for exactly 8 cycles.
- SUB 5-5 -> result 0, zero_o=1, cout_o=1, overflow_o=0. SUB 0x80000000-0x00000001 -> 0x7FFFFFFF, overflow_o=1, cout_o=1.
- SLT 0xFFFFFFFF vs 0x00000001 -> result 1. SLT 0x7FFFFFFF vs 0x80000000 -> result 0 (overflow-corrected). SLT 3 vs 3 -> 0, zero_o=1.
- Logic ops on A=0xF0F0F0F0, B=0xFF00FF00:
  - AND -> 0xF000F000.
  - OR -> 0xFFF0FFF0.
  - NOR -> 0x000F000F.
  - opcode 111 -> 0, zero_o=1.
  - All logic ops: cout_o=0, overflow_o=0.
- Handshake:
  - start_i pulses during RUN are ignored; changing src1_i/src2_i mid-RUN does not alter the result.
  - start_i asserted in the DONE cycle launches the next op; busy_o rises the following cycle.
- Drop rst_n mid-RUN -> all outputs 0 immediately, no done_o pulse; a fresh op afterwards completes correctly. Re-run ADD test with DIGIT=32 (N=1) and DIGIT=1 (N=32): identical results, latency 1 and 32.
